// File: rtl/shared_op_pkg.sv
// Shared definitions for the time-shared operator arbiter: FSM encoding,
// operator selection codes and a width helper.
package shared_op_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

  // Ceiling log2, never below 1 so it is always usable as a vector width.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic op_e op_from_name(input string name);
    if (name == "mul") return OP_MUL;
    if (name == "sub") return OP_SUB;
    return OP_ADD;
  endfunction

endpackage

// File: rtl/shared_op_operator.sv
// Combinational n-input operator: folds the packed operand vector left to
// right with add, sub or mul; results wrap modulo 2^data_width.
module shared_op_operator
  import shared_op_pkg::*;
#(
  parameter int  input_size = 2,
  parameter int  data_width = 32,
  parameter op_e op_code    = OP_ADD
) (
  input  logic [input_size*data_width-1:0] operands,
  output logic [data_width-1:0]            result
);

  logic [data_width-1:0] acc;
  logic [data_width-1:0] operand;

  always_comb begin
    acc     = operands[data_width-1:0];
    operand = '0;
    for (int i = 1; i < input_size; i++) begin
      operand = operands[i*data_width +: data_width];
      case (op_code)
        OP_ADD:  acc = acc + operand;
        OP_SUB:  acc = acc - operand;
        default: acc = acc * operand;
      endcase
    end
    result = acc;
  end

endmodule

// File: rtl/shared_op_rr_pick.sv
// Round-robin picker: first set request bit at or above ptr, wrapping
// modulo num_req. Purely combinational.
module shared_op_rr_pick
  import shared_op_pkg::*;
#(
  parameter int num_req = 4,
  parameter int id_w    = clog2(num_req)
) (
  input  logic [num_req-1:0] req,
  input  logic [id_w-1:0]    ptr,
  output logic [id_w-1:0]    winner,
  output logic               any_req
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int i = 0; i < num_req; i++) begin
      int idx;
      idx = (int'(ptr) + i) % num_req;
      if (!any_req && req[idx]) begin
        winner  = id_w'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_op_arbiter.sv
// Time-shares one arithmetic unit among num_req req/ack channels with
// round-robin selection; one operation every latency+2 cycles.
module shared_op_arbiter
  import shared_op_pkg::*;
#(
  parameter int    num_req    = 4,
  parameter int    data_width = 32,
  parameter string op         = "add",
  parameter int    latency    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [num_req-1:0]              req,
  input  logic [num_req*2*data_width-1:0] din,
  output logic [num_req-1:0]              ack,
  output logic [data_width-1:0]           dout,
  output logic [$clog2(num_req)-1:0]      grant_id,
  output logic                            busy,
  output logic [31:0]                     op_count
);

  localparam int  id_w   = clog2(num_req);
  localparam int  cnt_w  = (latency > 1) ? clog2(latency) : 1;
  localparam op_e op_sel = op_from_name(op);

  state_e                    state_q, state_d;
  logic [id_w-1:0]           ptr_q, ptr_d;
  logic [cnt_w-1:0]          cnt_q, cnt_d;
  logic [2*data_width-1:0]   operands_q, operands_d;
  logic [id_w-1:0]           grant_q, grant_d;
  logic [num_req-1:0]        ack_q, ack_d;
  logic [data_width-1:0]     dout_q, dout_d;
  logic                      busy_q, busy_d;
  logic [31:0]               op_count_q, op_count_d;

  logic [id_w-1:0]           pick_w;
  logic                      any_req;
  logic [data_width-1:0]     op_result;

  shared_op_rr_pick #(
    .num_req (num_req),
    .id_w    (id_w)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (pick_w),
    .any_req (any_req)
  );

  shared_op_operator #(
    .input_size (2),
    .data_width (data_width),
    .op_code    (op_sel)
  ) u_op (
    .operands (operands_q),
    .result   (op_result)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    operands_d = operands_q;
    grant_d    = grant_q;
    ack_d      = '0;
    dout_d     = dout_q;
    busy_d     = busy_q;
    op_count_d = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          // Channel slot is {b, a}, which is exactly the operator's operand order.
          operands_d = din[int'(pick_w)*2*data_width +: 2*data_width];
          grant_d    = pick_w;
          cnt_d      = cnt_w'(latency - 1);
          busy_d     = 1'b1;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          dout_d         = op_result;
          ack_d[grant_q] = 1'b1;
          op_count_d     = op_count_q + 32'd1;
          state_d        = ST_GAP;
        end
      end
      ST_GAP: begin
        // req is not looked at here, so a client re-raising req in its ack cycle waits its turn.
        busy_d  = 1'b0;
        ptr_d   = (grant_q == id_w'(num_req - 1)) ? '0 : grant_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      dout_q     <= '0;
      busy_q     <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      op_count_q <= op_count_d;
    end
  end

  // NOTE: operand register has no reset; it is always written at grant before it is consumed.
  always_ff @(posedge clk) begin
    operands_q <= operands_d;
  end

  assign ack      = ack_q;
  assign dout     = dout_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_shared_op_arbiter.sv
// Directed bench for shared_op_arbiter: a cycle-level behavioural model of the
// add/32-bit/latency-2 instance plus literal checks, and 8-bit mul/sub instances.
module tb_shared_op_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int DW8 = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NR-1:0]        req = '0;
  logic [NR*2*DW-1:0]   din = '0;
  logic [NR-1:0]        ack;
  logic [DW-1:0]        dout;
  logic [1:0]           grant_id;
  logic                 busy;
  logic [31:0]          op_count;

  logic [NR-1:0]        req8 = '0;
  logic [NR*2*DW8-1:0]  din_m = '0;
  logic [NR*2*DW8-1:0]  din_s = '0;
  logic [NR-1:0]        ack_m, ack_s;
  logic [DW8-1:0]       dout_m, dout_s;
  logic [1:0]           gid_m, gid_s;
  logic                 busy_m, busy_s;
  logic [31:0]          cnt_m, cnt_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  shared_op_arbiter #(.num_req(NR), .data_width(DW), .op("add"), .latency(LAT)) u_dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .ack(ack), .dout(dout),
    .grant_id(grant_id), .busy(busy), .op_count(op_count));

  shared_op_arbiter #(.num_req(NR), .data_width(DW8), .op("mul"), .latency(3)) u_mul (
    .clk(clk), .rst(rst), .req(req8), .din(din_m), .ack(ack_m), .dout(dout_m),
    .grant_id(gid_m), .busy(busy_m), .op_count(cnt_m));

  shared_op_arbiter #(.num_req(NR), .data_width(DW8), .op("sub"), .latency(3)) u_sub (
    .clk(clk), .rst(rst), .req(req8), .din(din_s), .ack(ack_s), .dout(dout_s),
    .grant_id(gid_s), .busy(busy_s), .op_count(cnt_s));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: an operation occupies the unit from its grant edge;
  // ack lands LAT edges after grant and the unit is free one edge later.
  bit            m_live = 0;
  bit            m_in_op;
  int            m_age, m_ptr, m_gid;
  logic [DW-1:0] m_a, m_b, m_dout;
  logic [NR-1:0] m_ack;
  bit            m_busy;
  logic [31:0]   m_count;

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1; m_in_op = 0; m_age = 0; m_ptr = 0; m_gid = 0;
      m_ack = '0; m_dout = '0; m_busy = 0; m_count = '0;
    end else if (m_live) begin
      m_ack = '0;
      if (m_in_op) begin
        m_age++;
        if (m_age == LAT) begin
          m_ack[m_gid] = 1'b1;
          m_dout = m_a + m_b;
          m_count = m_count + 1;
        end else if (m_age == LAT + 1) begin
          m_in_op = 0;
          m_busy  = 0;
          m_ptr   = (m_gid + 1) % NR;
        end
      end else if (req != '0) begin
        bit found;
        found = 0;
        for (int k = 0; k < NR; k++) begin
          int c;
          c = (m_ptr + k) % NR;
          if (!found && req[c]) begin
            found = 1;
            m_gid = c;
          end
        end
        m_a = din[2*DW*m_gid +: DW];
        m_b = din[2*DW*m_gid + DW +: DW];
        m_in_op = 1; m_age = 0; m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model_ack",      64'(ack),      64'(m_ack));
      check("model_dout",     64'(dout),     64'(m_dout));
      check("model_grant_id", 64'(grant_id), 64'(m_gid));
      check("model_busy",     64'(busy),     64'(m_busy));
      check("model_op_count", 64'(op_count), 64'(m_count));
    end
  end

  task automatic set_ops(input int ch, input logic [DW-1:0] a, input logic [DW-1:0] b);
    din[2*DW*ch +: DW]      = a;
    din[2*DW*ch + DW +: DW] = b;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output int when);
    bit ok;
    int i;
    ok = 0;
    i = 0;
    when = -1;
    while (!ok && i < budget) begin
      @(negedge clk);
      if (ack != '0) begin
        ok = 1;
        when = cyc;
      end
      i++;
    end
    check("ack_seen", 64'(ok), 64'd1);
  endtask

  initial begin
    int t_grant, t_ack, t_prev;
    logic [NR-1:0] exp_ack;

    // Reset held three cycles with every channel requesting.
    req = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ack",      64'(ack),      64'd0);
      check("rst_dout",     64'(dout),     64'd0);
      check("rst_busy",     64'(busy),     64'd0);
      check("rst_op_count", 64'(op_count), 64'd0);
    end
    rst = 1'b0;
    req = '0;

    // Single request on channel 2: 5 + 7.
    @(negedge clk);
    set_ops(2, 32'd5, 32'd7);
    req = 4'b0100;
    @(negedge clk);
    t_grant = cyc;
    check("single_grant_id", 64'(grant_id), 64'd2);
    check("single_busy",     64'(busy),     64'd1);
    wait_ack(10, t_ack);
    req = '0;
    check("single_ack",      64'(ack),      64'h4);
    check("single_latency",  64'(t_ack - t_grant), 64'd2);
    check("single_dout",     64'(dout),     64'd12);
    check("single_op_count", 64'(op_count), 64'd1);
    @(negedge clk);
    check("single_ack_clear", 64'(ack),  64'd0);
    check("single_busy_low",  64'(busy), 64'd0);

    // Round robin with all channels requesting continuously.
    reset_pulse();
    for (int i = 0; i < NR; i++) set_ops(i, DW'(i), 32'd10);
    req = '1;
    t_prev = -1;
    for (int i = 0; i < 5; i++) begin
      wait_ack(20, t_ack);
      exp_ack = 4'b0001 << (i % NR);
      check("rr_ack",  64'(ack),  64'(exp_ack));
      check("rr_dout", 64'(dout), 64'(i % NR + 10));
      if (i > 0) check("rr_spacing", 64'(t_ack - t_prev), 64'(LAT + 2));
      t_prev = t_ack;
    end
    req = '0;
    repeat (3) @(negedge clk);

    // Reset one cycle after grant abandons the operation.
    reset_pulse();
    set_ops(0, 32'd1, 32'd1);
    req = 4'b0001;
    @(negedge clk);
    check("mid_grant_id", 64'(grant_id), 64'd0);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_no_ack", 64'(ack), 64'd0);
    end
    check("mid_op_count", 64'(op_count), 64'd0);
    set_ops(1, 32'd20, 32'd22);
    req = 4'b0010;
    wait_ack(10, t_ack);
    req = '0;
    check("mid_next_ack",  64'(ack),  64'h2);
    check("mid_next_dout", 64'(dout), 64'd42);
    repeat (3) @(negedge clk);

    // Ch0 keeps requesting through its ack; ch3 must be next. Ch0 operands change mid-EXEC.
    reset_pulse();
    set_ops(0, 32'd100, 32'd1);
    set_ops(3, 32'd7, 32'd8);
    req = 4'b1001;
    @(negedge clk);
    set_ops(0, 32'd999, 32'd999);
    wait_ack(10, t_ack);
    check("rereq_ack0",  64'(ack),  64'h1);
    check("rereq_dout0", 64'(dout), 64'd101);
    wait_ack(10, t_ack);
    check("rereq_ack3",  64'(ack),  64'h8);
    check("rereq_dout3", 64'(dout), 64'd15);
    req = '0;
    repeat (4) @(negedge clk);

    // 8-bit wrap: mul FF*02 and sub 3-5 both give FE.
    din_m[7:0]  = 8'hFF;
    din_m[15:8] = 8'h02;
    din_s[7:0]  = 8'h03;
    din_s[15:8] = 8'h05;
    req8 = 4'b0001;
    begin
      bit ok;
      int i;
      ok = 0;
      i = 0;
      while (!ok && i < 12) begin
        @(negedge clk);
        if (ack_m != '0) ok = 1;
        i++;
      end
      check("w8_ack_seen", 64'(ok), 64'd1);
    end
    req8 = '0;
    check("mul_ack",  64'(ack_m),  64'h1);
    check("sub_ack",  64'(ack_s),  64'h1);
    check("mul_dout", 64'(dout_m), 64'hFE);
    check("sub_dout", 64'(dout_s), 64'hFE);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
